branch_flag_unit: RTL

BRANCH_FLAG_UNIT -- requirements
Module: branch_flag_unit

---
 rtl/branch_flag_unit.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/branch_flag_unit.sv
// Branch resolution unit: registers ALU flags, resolves a branch condition and
// holds the result until downstream accepts it. Optional macro: BRANCH_FLAG_BYPASS_EN.
module branch_flag_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [31:0] alu_result,
  input  logic        zero_flag,
  input  logic        carry_flag,
  input  logic        sign_flag,
  input  logic        overflow_flag,
  input  logic        flag_we,
  input  logic        br_valid,
  output logic        br_ready,
  input  logic [3:0]  br_cond,
  input  logic [31:0] br_pc,
  input  logic [31:0] br_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        taken,
  output logic [31:0] next_pc,
  output logic        illegal,
  output logic        link_we,
  output logic [31:0] link_data,
  output logic [3:0]  flags_q
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [3:0] COND_AL    = 4'b0000;
  localparam logic [3:0] COND_EQ    = 4'b0001;
  localparam logic [3:0] COND_NE    = 4'b0010;
  localparam logic [3:0] COND_CS    = 4'b0011;
  localparam logic [3:0] COND_CC    = 4'b0100;
  localparam logic [3:0] COND_MI    = 4'b0101;
  localparam logic [3:0] COND_PL    = 4'b0110;
  localparam logic [3:0] COND_VS    = 4'b0111;
  localparam logic [3:0] COND_VC    = 4'b1000;
  localparam logic [3:0] COND_LINK  = 4'b1001;
  localparam logic [3:0] COND_RNEG  = 4'b1010;
  localparam logic [3:0] COND_RZERO = 4'b1011;

  state_t      state;
  state_t      state_next;
  logic        accept;
  logic [3:0]  flags_in;
  logic [3:0]  eval_flags;
  logic        flag_z;
  logic        flag_c;
  logic        flag_s;
  logic        flag_v;
  logic        cond_taken;
  logic        cond_illegal;
  logic        cond_link;
  logic [31:0] pc_plus4;

  assign flags_in = {overflow_flag, sign_flag, carry_flag, zero_flag};
  assign accept   = (state == IDLE) && br_valid;
  assign pc_plus4 = br_pc + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'd0;
    end else if (alu_valid && flag_we) begin
      flags_q <= flags_in;
    end
  end

`ifdef BRANCH_FLAG_BYPASS_EN
  // Forward a same-cycle flag write so a dependent branch sees the new flags.
  assign eval_flags = (alu_valid && flag_we) ? flags_in : flags_q;
`else
  assign eval_flags = flags_q;
`endif

  assign flag_z = eval_flags[0];
  assign flag_c = eval_flags[1];
  assign flag_s = eval_flags[2];
  assign flag_v = eval_flags[3];

  always_comb begin
    cond_taken   = 1'b0;
    cond_illegal = 1'b0;
    cond_link    = 1'b0;
    case (br_cond)
      COND_AL:    cond_taken = 1'b1;
      COND_EQ:    cond_taken = flag_z;
      COND_NE:    cond_taken = !flag_z;
      COND_CS:    cond_taken = flag_c;
      COND_CC:    cond_taken = !flag_c;
      COND_MI:    cond_taken = flag_s;
      COND_PL:    cond_taken = !flag_s;
      COND_VS:    cond_taken = flag_v;
      COND_VC:    cond_taken = !flag_v;
      COND_LINK: begin
        cond_taken = 1'b1;
        cond_link  = 1'b1;
      end
      // Result-based codes only trust alu_result when it is actually present.
      COND_RNEG:  cond_taken = alu_valid && alu_result[31];
      COND_RZERO: cond_taken = alu_valid && (alu_result == 32'd0);
      default:    cond_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (br_valid)  state_next = HOLD;
      HOLD: if (out_ready) state_next = IDLE;
      default:             state_next = IDLE;
    endcase
  end

  always_comb begin
    br_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    br_ready  = rst_n;
      HOLD:    out_valid = 1'b1;
      default: br_ready  = 1'b0;
    endcase
  end

  // Result registers only load on accept, so they stay frozen throughout HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken     <= 1'b0;
      next_pc   <= 32'd0;
      illegal   <= 1'b0;
      link_we   <= 1'b0;
      link_data <= 32'd0;
    end else if (accept) begin
      taken     <= cond_taken;
      next_pc   <= cond_taken ? br_target : pc_plus4;
      illegal   <= cond_illegal;
      link_we   <= cond_link;
      link_data <= cond_link ? pc_plus4 : 32'd0;
    end
  end

endmodule
